panel_debounce: RTL
===================

PANEL_DEBOUNCE -- requirements
Module: panel_debounce

Interface
REQ-001 The block SHALL have one parameter DEBOUNCE_CYCLES, default 1000, giving the number of consecutive stable cycles needed to accept a new input level (legal range 1..65535).
REQ-002 The block SHALL have one parameter REPEAT_DELAY, default 500000, giving the cycles a held step button waits before auto-repeat starts (used only with the macro).
REQ-003 The block SHALL have one parameter REPEAT_PERIOD, default 100000, giving the cycles between auto-repeat pulses (used only with the macro).
REQ-004 i_clk  in  1  single system clock; all logic on its rising edge.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 i_rawBtnStep, i_rawBtnReset  in  1 each  asynchronous front-panel buttons, 1 = closed.
REQ-007 i_rawSwInstrNCycle, i_rawSwStepNRun, i_rawSwEnableBreakpoint  in  1 each  asynchronous front-panel switches, 1 = closed.
REQ-008 o_btnStep, o_btnReset, o_swInstrNCycle, o_swStepNRun, o_swEnableBreakpoint  out  1 each  debounced levels, 1 = closed; these feed the clock controller.
REQ-009 o_stepPulse  out  1  one-cycle pulse per accepted step press (and per repeat with the macro).
REQ-010 o_anyChange  out  1  one-cycle pulse in any cycle where at least one debounced level changes.

Function
REQ-011 Each of the 5 raw inputs SHALL pass through its own 2-flop synchronizer before any other logic.
REQ-012 Each input SHALL have an independent counter; it SHALL clear whenever the synchronized value equals the debounced level, and otherwise increment by 1 per cycle.
REQ-013 When an input's counter reaches DEBOUNCE_CYCLES-1 while it still differs, the next edge SHALL load the synchronized value into the debounced level and clear the counter.
REQ-014 Latency: a clean raw change sampled at edge N SHALL appear on its debounced output after edge N+1+DEBOUNCE_CYCLES.
REQ-015 Any return of the synchronized value to the debounced level before acceptance (bounce) SHALL clear the counter, so the full window restarts.
REQ-016 Counters SHALL be wide enough for DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-017 The step FSM SHALL have states IDLE and HELD (plus DELAY and REPEAT with the macro).
REQ-018 IDLE->HELD SHALL occur on a debounced step 0->1, and o_stepPulse SHALL be 1 in exactly that transition cycle.
REQ-019 Any state SHALL return to IDLE when debounced step is 0, with no pulse.
REQ-020 o_anyChange SHALL be 1 for one cycle whenever one or more debounced levels update; simultaneous updates SHALL produce a single pulse.
REQ-021 o_btnReset SHALL be debounced exactly like the other inputs, with no bypass path.

Reset
REQ-022 While i_reset is high at a clock edge: all synchronizer flops, debounced levels and counters SHALL be 0, the FSM SHALL be IDLE, and o_stepPulse and o_anyChange SHALL be 0.
REQ-023 Reset mid-count SHALL discard partial counts; an input held closed through reset SHALL be re-accepted DEBOUNCE_CYCLES+2 cycles after reset deasserts.

Configuration
REQ-024 Macro PANEL_STEP_AUTOREPEAT_EN SHALL control step auto-repeat.
REQ-025 With the macro defined: HELD->DELAY on the next cycle; after REPEAT_DELAY cycles in DELAY, go to REPEAT and emit a pulse; in REPEAT, emit a pulse every REPEAT_PERIOD cycles; release returns to IDLE and clears the repeat counter.
REQ-026 Without the macro: the FSM SHALL stay in HELD while the button is held, with no repeat counter and exactly one pulse per press.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-027 Clean step press at edge 0, held -> o_btnStep=1 after edge 5; o_stepPulse high for exactly one cycle; o_anyChange pulses in the same cycle.
REQ-028 i_rawSwStepNRun toggles 1,0,1,0 on alternate cycles, then holds 1 -> no output change until 4 stable synchronized cycles; exactly one change.
REQ-029 Step and breakpoint switch close in the same cycle -> both outputs rise in the same cycle; single o_anyChange pulse.
REQ-030 Reset asserted at count 2 with input held closed -> outputs 0 during reset; output rises 6 cycles after reset release.
REQ-031 With macro, step held 30 cycles -> pulses at press acceptance, then +11, +14, +17, ...; after release, no further pulses. Without macro -> exactly 1 pulse.
REQ-032 Raw input glitch lasting 1 cycle -> no change on any output.

Source files
------------

// File: rtl/panel_debounce.sv
// panel_debounce: front-panel button/switch conditioner.
// Each raw input passes through a 2-flop synchronizer, then an independent
// stable-count debouncer. A small step FSM turns the debounced step button
// into one-cycle step pulses.
// Optional feature macro: PANEL_STEP_AUTOREPEAT_EN enables step auto-repeat
// (DELAY/REPEAT states driven by REPEAT_DELAY and REPEAT_PERIOD).
module panel_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_PERIOD   = 100000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_rawBtnStep,
    input  logic i_rawBtnReset,
    input  logic i_rawSwInstrNCycle,
    input  logic i_rawSwStepNRun,
    input  logic i_rawSwEnableBreakpoint,
    output logic o_btnStep,
    output logic o_btnReset,
    output logic o_swInstrNCycle,
    output logic o_swStepNRun,
    output logic o_swEnableBreakpoint,
    output logic o_stepPulse,
    output logic o_anyChange
);
    localparam int N  = 5;
    // Counter only needs to hold DEBOUNCE_CYCLES-1, so it can never wrap.
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Reject illegal configurations at elaboration time.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("panel_debounce: parameter out of range");
    end

    // Lane order: 0 step, 1 reset button, 2 instr/cycle, 3 step/run, 4 breakpoint.
    logic [N-1:0]         raw;
    logic [N-1:0]         sync1_q, sync2_q;
    logic [N-1:0]         level_q, level_d;
    logic [N-1:0][CW-1:0] cnt_q, cnt_d;
    logic                 any_q;

    assign raw = {i_rawSwEnableBreakpoint, i_rawSwStepNRun, i_rawSwInstrNCycle,
                  i_rawBtnReset, i_rawBtnStep};

    // Two-flop synchronizers for the asynchronous panel inputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Per-lane debounce: count cycles of disagreement, accept after the full window.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < N; i++) begin
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                level_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Debounced levels, counters and the registered change strobe.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            level_q <= '0;
            cnt_q   <= '0;
            any_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            any_q   <= (level_d != level_q);
        end
    end

    assign o_btnStep            = level_q[0];
    assign o_btnReset           = level_q[1];
    assign o_swInstrNCycle      = level_q[2];
    assign o_swStepNRun         = level_q[3];
    assign o_swEnableBreakpoint = level_q[4];
    assign o_anyChange          = any_q;

`ifdef PANEL_STEP_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {S_IDLE, S_HELD, S_DELAY, S_REPEAT} state_t;
    state_t        state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;

    // Step FSM state and repeat counter registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
        end
    end

    // Next state: release always wins; repeat counter restarts after each repeat pulse.
    always_comb begin
        state_d = state_q;
        rcnt_d  = '0;
        if (!level_q[0]) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_HELD;
                S_HELD:  state_d = S_DELAY;
                S_DELAY: begin
                    if (rcnt_q == DLY_LAST) state_d = S_REPEAT;
                    else                    rcnt_d  = rcnt_q + RW'(1);
                end
                S_REPEAT: begin
                    if (rcnt_q != PER_LAST) rcnt_d = rcnt_q + RW'(1);
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Pulse on acceptance, on leaving DELAY, and each REPEAT period while held.
    always_comb begin
        o_stepPulse = 1'b0;
        if (level_q[0]) begin
            case (state_q)
                S_IDLE:   o_stepPulse = 1'b1;
                S_DELAY:  o_stepPulse = (rcnt_q == DLY_LAST);
                S_REPEAT: o_stepPulse = (rcnt_q == PER_LAST);
                default:  o_stepPulse = 1'b0;
            endcase
        end
    end
`else
    typedef enum logic {S_IDLE, S_HELD} state_t;
    state_t state_q, state_d;

    // Step FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next state: HELD while the debounced button stays closed.
    always_comb begin
        state_d = level_q[0] ? S_HELD : S_IDLE;
    end

    // One pulse per press, in the IDLE->HELD transition cycle.
    always_comb begin
        o_stepPulse = (state_q == S_IDLE) && level_q[0];
    end
`endif

endmodule
